// File: rtl/fft_frame_reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_reorder_pkg
//  Description : Shared types and helpers for the FFT frame reorder block:
//                bank life-cycle states, FSM state types, address width and
//                the bit-reversal helper used on the write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_frame_reorder_pkg;

    // Default frame length and its address width
    localparam int N_DEFAULT  = 256;
    localparam int ADDR_W     = $clog2(N_DEFAULT);

    // Widest address the bit-reversal helper supports
    localparam int MAX_ADDR_W = 16;

    // Life cycle of one ping-pong bank
    typedef enum logic [1:0] {
        B_FREE     = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_e;

    // Upstream fetch sequencer
    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_e;

    // Downstream output sequencer
    typedef enum logic [0:0] {
        O_IDLE   = 1'b0,
        O_STREAM = 1'b1
    } out_state_e;

    // Reverse the low 'width' bits of 'value'. The full word is mirrored
    // first, then shifted down so the reversed field lands at bit 0.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(
        input logic [MAX_ADDR_W-1:0] value,
        input int                    width
    );
        logic [MAX_ADDR_W-1:0] mirrored;
        for (int i = 0; i < MAX_ADDR_W; i++) begin
            mirrored[i] = value[MAX_ADDR_W-1-i];
        end
        return mirrored >> (MAX_ADDR_W - width);
    endfunction

endpackage : fft_frame_reorder_pkg
`default_nettype wire

// File: rtl/fft_frame_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_reorder_if
//  Description : Bundles the upstream fetch handshake, the FFT output stream
//                and the error flag of the frame reorder block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fft_frame_reorder_if
    import fft_frame_reorder_pkg::*;
#(
    parameter int Q_DATA = 15
);
    // Upstream side
    logic                 paquet_ready;
    logic                 valid_in;
    logic signed [Q_DATA:0] data_in;
    logic                 valid_fft;

    // FFT side
    logic                 fft_ready;
    logic                 fft_valid;
    logic                 fft_last;
    logic signed [Q_DATA:0] fft_re;
    logic signed [Q_DATA:0] fft_im;

    // Sticky error
    logic                 overflow;

    // Environment view: drives the inputs of the block
    modport master (
        output paquet_ready, valid_in, data_in, fft_ready,
        input  valid_fft, fft_valid, fft_last, fft_re, fft_im, overflow
    );

    // Block view
    modport slave (
        input  paquet_ready, valid_in, data_in, fft_ready,
        output valid_fft, fft_valid, fft_last, fft_re, fft_im, overflow
    );

endinterface : fft_frame_reorder_if
`default_nettype wire

// File: rtl/fft_frame_reorder_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pingpong_ram
//  Description : Simple dual-port RAM of 2*N words. Address MSB selects the
//                bank. One write port, one read port with a registered,
//                enable-gated output that doubles as the output holding stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_pingpong_ram
    import fft_frame_reorder_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int AW     = 8
)(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              we_i,
    input  wire logic [AW:0]       waddr_i,
    input  wire logic [DATA_W-1:0] wdata_i,
    input  wire logic              re_i,
    input  wire logic [AW:0]       raddr_i,
    output      logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 * (1 << AW);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [DATA_W-1:0] rdata_q;

    // Storage array: written on demand, contents survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read register: holds its value while re_i is low so a stalled
    // output word stays stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fft_pingpong_ram
`default_nettype wire

// File: rtl/fft_frame_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_reorder
//  Description : Pulls N-sample frames from the overlapping frame buffer,
//                stores them bit-reversed in a ping-pong RAM and streams each
//                complete frame to the FFT core with valid/ready/last.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_reorder
    import fft_frame_reorder_pkg::*;
#(
    parameter int Q_DATA = 15,
    parameter int N      = 256
)(
    input  wire logic           clk,
    input  wire logic           reset,
    fft_frame_reorder_if.slave  bus
);
    localparam int AW     = $clog2(N);
    localparam int DATA_W = Q_DATA + 1;

    typedef logic [AW-1:0] addr_t;
    typedef logic [AW:0]   rcnt_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]   pending_q, pending_d;
    logic         overflow_q, overflow_d;
    bank_state_e  bank_q [2];
    bank_state_e  bank_d [2];

    fetch_state_e fstate_q, fstate_d;
    addr_t        req_cnt_q, req_cnt_d;
    logic         wr_bank_q, wr_bank_d;
    addr_t        wr_cnt_q, wr_cnt_d;

    out_state_e   ostate_q, ostate_d;
    logic         rd_bank_q, rd_bank_d;
    rcnt_t        rd_cnt_q, rd_cnt_d;     // MSB set once all N reads issued
    logic         valid_q, valid_d;
    logic         last_q, last_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic              w_fetch_start;
    logic              w_wr_filling;
    logic              w_wr_en;
    addr_t             w_wr_addr;
    logic              w_accept;
    logic              w_last_accept;
    logic              w_other_full;
    logic              w_out_start;
    logic              w_load;
    logic [DATA_W-1:0] w_rd_data;

    assign w_fetch_start = (fstate_q == F_IDLE) && (pending_q != 2'd0)
                           && (bank_q[wr_bank_q] == B_FREE);
    assign w_wr_filling  = (bank_q[wr_bank_q] == B_FILLING);
    assign w_wr_en       = bus.valid_in && w_wr_filling;
    assign w_wr_addr     = addr_t'(bitrev(MAX_ADDR_W'(wr_cnt_q), AW));

    assign w_accept      = valid_q && bus.fft_ready;
    assign w_last_accept = w_accept && last_q;
    assign w_other_full  = (bank_q[~rd_bank_q] == B_FULL);
    assign w_out_start   = (ostate_q == O_IDLE) && (bank_q[rd_bank_q] == B_FULL);

    // A new read is issued only when the holding register is empty or is
    // being emptied this cycle, so a stalled word is never overwritten.
    assign w_load        = (ostate_q == O_STREAM) && !rd_cnt_q[AW]
                           && (!valid_q || bus.fft_ready);

    // Pending-frame counter and sticky overflow flag
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (bus.paquet_ready && !w_fetch_start) begin
            if (pending_q == 2'd3) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 2'd1;
            end
        end else if (!bus.paquet_ready && w_fetch_start) begin
            pending_d = pending_q - 2'd1;
        end
        // A sample with nowhere to go is lost
        if (bus.valid_in && !w_wr_filling) begin
            overflow_d = 1'b1;
        end
    end

    // Bank life-cycle transitions; each event touches a distinct bank
    always_comb begin
        bank_d = bank_q;
        if (w_fetch_start) begin
            bank_d[wr_bank_q] = B_FILLING;
        end
        if (fstate_q == F_WAIT) begin
            bank_d[wr_bank_q] = B_FULL;
        end
        if (w_out_start) begin
            bank_d[rd_bank_q] = B_DRAINING;
        end
        if (w_last_accept) begin
            bank_d[rd_bank_q] = B_FREE;
            if (w_other_full) begin
                bank_d[~rd_bank_q] = B_DRAINING;
            end
        end
    end

    // Fetch FSM: N-cycle request burst, then one cycle for the trailing sample
    always_comb begin
        fstate_d  = fstate_q;
        req_cnt_d = req_cnt_q;
        wr_bank_d = wr_bank_q;
        unique case (fstate_q)
            F_IDLE: begin
                if (w_fetch_start) begin
                    fstate_d  = F_REQ;
                    req_cnt_d = '0;
                end
            end
            F_REQ: begin
                req_cnt_d = req_cnt_q + addr_t'(1);
                if (req_cnt_q == addr_t'(N - 1)) begin
                    fstate_d = F_WAIT;
                end
            end
            F_WAIT: begin
                wr_bank_d = ~wr_bank_q;
                fstate_d  = F_IDLE;
            end
            default: begin
                fstate_d = F_IDLE;
            end
        endcase
    end

    // Write counter: one step per stored sample, wraps naturally at N
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (w_wr_en) begin
            wr_cnt_d = wr_cnt_q + addr_t'(1);
        end
    end

    // Output FSM: linear reads through the bank, holding-register handshake
    always_comb begin
        ostate_d  = ostate_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        valid_d   = valid_q;
        last_d    = last_q;
        unique case (ostate_q)
            O_IDLE: begin
                if (w_out_start) begin
                    ostate_d = O_STREAM;
                    rd_cnt_d = '0;
                end
            end
            O_STREAM: begin
                if (w_load) begin
                    rd_cnt_d = rd_cnt_q + rcnt_t'(1);
                    valid_d  = 1'b1;
                    last_d   = (rd_cnt_q == rcnt_t'(N - 1));
                end else if (w_accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                // Chain straight into the other bank when it is ready
                if (w_last_accept) begin
                    rd_bank_d = ~rd_bank_q;
                    if (w_other_full) begin
                        rd_cnt_d = '0;
                    end else begin
                        ostate_d = O_IDLE;
                    end
                end
            end
            default: begin
                ostate_d = O_IDLE;
            end
        endcase
    end

    // State registers; a reset drops any frame in flight immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q  <= 2'd0;
            overflow_q <= 1'b0;
            bank_q[0]  <= B_FREE;
            bank_q[1]  <= B_FREE;
            fstate_q   <= F_IDLE;
            req_cnt_q  <= '0;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            ostate_q   <= O_IDLE;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            bank_q     <= bank_d;
            fstate_q   <= fstate_d;
            req_cnt_q  <= req_cnt_d;
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            ostate_q   <= ostate_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    fft_pingpong_ram #(
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_wr_en),
        .waddr_i ({wr_bank_q, w_wr_addr}),
        .wdata_i (bus.data_in),
        .re_i    (w_load),
        .raddr_i ({rd_bank_q, rd_cnt_q[AW-1:0]}),
        .rdata_o (w_rd_data)
    );

    assign bus.valid_fft = (fstate_q == F_REQ);
    assign bus.fft_valid = valid_q;
    assign bus.fft_last  = last_q;
    assign bus.fft_re    = w_rd_data;
    assign bus.fft_im    = '0;
    assign bus.overflow  = overflow_q;

endmodule : fft_frame_reorder
`default_nettype wire

// File: tb/tb_fft_frame_reorder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_reorder
//  Description : Self-checking bench for fft_frame_reorder (N = 8). An
//                upstream responder answers each valid_fft cycle with one
//                sample; a frame-level model predicts the FFT stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_reorder;

    localparam int Q_DATA = 15;
    localparam int N      = 8;
    localparam int AW     = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fft_frame_reorder_if #(.Q_DATA(Q_DATA)) bus ();

    fft_frame_reorder #(.Q_DATA(Q_DATA), .N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_assert;
    int          n_fail;
    int          cyc;
    logic        prev_vfft;
    logic        prev_stall;
    logic [15:0] prev_re;
    logic        prev_last;
    logic [15:0] cur_frame[$];
    logic [15:0] exp_re[$];
    logic        exp_last[$];
    logic [15:0] rec[$];
    int          run_len, bursts, frames_in, frames_out;
    int          last_vin_cyc, first_fv_cyc, first_acc, last_acc;
    bit          first_seen, ramp_mode, inj, found;
    int          ramp_exp[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int          pat[4]      = '{1, 0, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if ((k >> b) % 2 == 1) r += 1 << (AW - 1 - b);
        end
        return r;
    endfunction

    task automatic reset_counters();
        bursts = 0; frames_in = 0; frames_out = 0;
        first_seen = 0; first_acc = -1; last_acc = -1;
        rec.delete();
    endtask

    task automatic clear_model();
        cur_frame.delete(); exp_re.delete(); exp_last.delete();
        prev_vfft = 0; prev_stall = 0; run_len = 0;
        reset_counters();
    endtask

    // One clock cycle: drive inputs, run the upstream responder and check
    // the FFT stream against the frame model.
    task automatic tick(input logic pr, input logic rdy);
        logic [15:0] re_now;
        @(posedge clk); #1;
        cyc++;
        re_now = $unsigned(bus.fft_re);
        if (prev_stall) begin
            chk("stall_valid", 32'(bus.fft_valid), 32'd1);
            chk("stall_re", 32'(re_now), 32'(prev_re));
            chk("stall_last", 32'(bus.fft_last), 32'(prev_last));
        end
        bus.paquet_ready = pr;
        bus.fft_ready    = rdy;
        if (prev_vfft) begin
            bus.valid_in = 1'b1;
            bus.data_in  = ramp_mode ? 16'(cur_frame.size()) : 16'($urandom);
            cur_frame.push_back($unsigned(bus.data_in));
            last_vin_cyc = cyc;
            if (cur_frame.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_re.push_back(cur_frame[brev(k)]);
                    exp_last.push_back(k == N - 1);
                end
                frames_in++;
                cur_frame.delete();
            end
        end else if (inj) begin
            bus.valid_in = 1'b1;
            bus.data_in  = 16'($urandom);
            inj = 0;
        end else begin
            bus.valid_in = 1'b0;
            bus.data_in  = '0;
        end
        if (bus.valid_fft) begin
            run_len++;
        end else if (run_len != 0) begin
            chk("burst_len", 32'(run_len), 32'(N));
            bursts++;
            run_len = 0;
        end
        prev_vfft = bus.valid_fft;
        if (bus.fft_valid) begin
            chk("fft_im", 32'($unsigned(bus.fft_im)), 32'd0);
            if (!first_seen) begin
                first_seen   = 1;
                first_fv_cyc = cyc;
            end
        end
        if (bus.fft_valid && rdy) begin
            n_assert++;
            assert (exp_re.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_out observed=%0h expected=no_output", re_now);
            end
            if (exp_re.size() != 0) begin
                chk("fft_re", 32'(re_now), 32'(exp_re.pop_front()));
                chk("fft_last", 32'(bus.fft_last), 32'(exp_last.pop_front()));
            end
            rec.push_back(re_now);
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (bus.fft_last) frames_out++;
        end
        prev_stall = bus.fft_valid && !rdy;
        prev_re    = re_now;
        prev_last  = bus.fft_last;
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0; inj = 0; ramp_mode = 0;
        clear_model();
        reset = 1'b1;
        bus.paquet_ready = 1'b0; bus.valid_in = 1'b0;
        bus.data_in = '0; bus.fft_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_fft", 32'(bus.valid_fft), 32'd0);
        chk("rst_fft_valid", 32'(bus.fft_valid), 32'd0);
        chk("rst_fft_last", 32'(bus.fft_last), 32'd0);
        chk("rst_fft_re", 32'($unsigned(bus.fft_re)), 32'd0);
        chk("rst_fft_im", 32'($unsigned(bus.fft_im)), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single ramp frame: bit-reversed order, latency, back-to-back output
        ramp_mode = 1;
        reset_counters();
        tick(1'b1, 1'b1);
        repeat (30) tick(1'b0, 1'b1);
        chk("ramp_count", 32'(rec.size()), 32'(N));
        for (int k = 0; k < N && k < rec.size(); k++) begin
            chk("ramp_order", 32'(rec[k]), 32'(ramp_exp[k]));
        end
        chk("first_latency", 32'(first_fv_cyc - last_vin_cyc), 32'd3);
        chk("consecutive_out", 32'(last_acc - first_acc), 32'(N - 1));
        chk("ramp_frames", 32'(frames_out), 32'd1);
        ramp_mode = 0;

        // Three pulses four cycles apart, random data
        reset_counters();
        for (int p = 0; p < 3; p++) begin
            tick(1'b1, 1'b1);
            repeat (3) tick(1'b0, 1'b1);
        end
        repeat (80) tick(1'b0, 1'b1);
        chk("three_bursts", 32'(bursts), 32'd3);
        chk("three_frames", 32'(frames_out), 32'd3);
        chk("three_ovf", 32'(bus.overflow), 32'd0);
        chk("three_drained", 32'(exp_re.size()), 32'd0);

        // Back-pressure pattern 1,0,0,1
        reset_counters();
        for (int i = 0; i < 160; i++) begin
            tick((i == 0 || i == 4) ? 1'b1 : 1'b0, pat[i % 4] != 0);
        end
        chk("stall_frames", 32'(frames_out), 32'd2);
        chk("stall_drained", 32'(exp_re.size()), 32'd0);

        // Five pulses with the FFT stalled: pending saturates, overflow sticks
        reset_counters();
        repeat (5) tick(1'b1, 1'b0);
        repeat (60) tick(1'b0, 1'b0);
        chk("sat_overflow", 32'(bus.overflow), 32'd1);
        chk("sat_bursts", 32'(bursts), 32'd2);
        chk("sat_vfft_idle", 32'(bus.valid_fft), 32'd0);
        repeat (150) tick(1'b0, 1'b1);
        chk("sat_frames", 32'(frames_out), 32'd4);
        chk("sat_ovf_sticky", 32'(bus.overflow), 32'd1);
        chk("sat_drained", 32'(exp_re.size()), 32'd0);

        @(negedge clk); reset = 1'b1;
        clear_model();
        @(negedge clk); reset = 1'b0;
        chk("ovf_cleared", 32'(bus.overflow), 32'd0);

        // Stray valid_in with no fetch active
        inj = 1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        chk("stray_overflow", 32'(bus.overflow), 32'd1);
        repeat (20) tick(1'b0, 1'b1);
        chk("stray_no_output", 32'(rec.size()), 32'd0);

        // Reset in the middle of a burst while a frame waits at the output
        reset_counters();
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(i < 2 ? 1'b1 : 1'b0, 1'b0);
            if (frames_in >= 1 && cur_frame.size() == 3) found = 1;
        end
        chk("midburst_found", 32'(found), 32'd1);
        chk("pre_rst_vfft", 32'(bus.valid_fft), 32'd1);
        chk("pre_rst_fft_valid", 32'(bus.fft_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_vfft", 32'(bus.valid_fft), 32'd0);
        chk("async_fft_valid", 32'(bus.fft_valid), 32'd0);
        chk("async_overflow", 32'(bus.overflow), 32'd0);
        bus.valid_in = 1'b0; bus.paquet_ready = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk); reset = 1'b0;

        ramp_mode = 1;
        tick(1'b1, 1'b1);
        repeat (40) tick(1'b0, 1'b1);
        chk("post_rst_count", 32'(rec.size()), 32'(N));
        for (int k = 0; k < N && k < rec.size(); k++) begin
            chk("post_rst_order", 32'(rec[k]), 32'(ramp_exp[k]));
        end
        chk("post_rst_ovf", 32'(bus.overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fft_frame_reorder
`default_nettype wire

// File: doc/fft_frame_reorder.md
Name: fft_frame_reorder

Overview:
- Sits directly downstream of the overlapping frame buffer, between it and the FFT core.
- Each `paquet_ready` pulse marks one N-sample frame as available upstream. This block pulls that frame with an N-cycle `valid_fft` burst.
- Samples are stored in bit-reversed order in a ping-pong buffer.
- Each complete frame is streamed to the FFT as a valid/ready stream with an end-of-frame marker.

Parameters:
- Q_DATA, 15, MSB index of the sample word; word width is Q_DATA+1, signed.
- N, 256, frame length; power of two, at least 8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- paquet_ready  in  1  one-cycle pulse: one more frame is ready upstream.
- valid_in  in  1  upstream sample valid; follows each `valid_fft` cycle by exactly 1 cycle.
- data_in  in  Q_DATA+1  signed upstream sample.
- valid_fft  out  1  read request to upstream; held high for exactly N consecutive cycles per frame.
- fft_ready  in  1  FFT core accepts a sample this cycle.
- fft_valid  out  1  output sample valid.
- fft_last  out  1  high together with `fft_valid` on sample N-1 of a frame.
- fft_re  out  Q_DATA+1  real part, equal to the stored sample.
- fft_im  out  Q_DATA+1  imaginary part, constant 0.
- overflow  out  1  sticky error flag; cleared only by `reset`.

Behaviour:
- Reset values (asynchronous):
  - All outputs 0.
  - Pending count 0; both banks FREE; FSMs idle.
  - RAM contents are not reset.
- Pending counter, 2 bits:
  - Incremented by `paquet_ready`; decremented when a fetch starts.
  - If both happen in the same cycle, the count is unchanged.
  - If `paquet_ready` arrives while count = 3, the count stays 3 and `overflow` is set.
- Banks: two banks of N words, each FREE -> FILLING -> FULL -> DRAINING -> FREE.
  - The fetch FSM fills banks alternately, starting with bank 0.
  - The output FSM drains banks in the same order.
- Fetch FSM, states F_IDLE, F_REQ, F_WAIT:
  - F_IDLE -> F_REQ when pending > 0 and the next write bank is FREE. On this transition: decrement pending, mark the bank FILLING, assert `valid_fft` from the next cycle.
  - F_REQ: `valid_fft` = 1 for N cycles. The request counter wraps at N-1, then -> F_WAIT.
  - F_WAIT: lasts 1 cycle, catches the final `valid_in`. The bank becomes FULL, write bank toggles, -> F_IDLE.
  - Back-to-back frames therefore have at least one idle `valid_fft` cycle between bursts.
- Write path:
  - On each `valid_in`, store `data_in` at address bitrev(write counter), log2(N) bits, then increment the counter.
  - The write counter wraps to 0 after N-1.
  - `valid_in` while no bank is FILLING is discarded and sets `overflow`.
- Output FSM, states O_IDLE, O_STREAM:
  - O_IDLE -> O_STREAM when the next read bank is FULL; the bank becomes DRAINING.
  - The RAM read is synchronous. The output stage is a one-entry holding register, refilled when it is empty or when `fft_valid && fft_ready`.
  - First `fft_valid` is 2 cycles after the bank becomes FULL.
  - With `fft_ready` held at 1, N consecutive output cycles.
- Output handshake:
  - While `fft_valid && !fft_ready`, `fft_re`, `fft_im` and `fft_last` stay stable and the read address does not advance.
  - `fft_valid` never drops before the sample is accepted.
- End of frame:
  - On acceptance of the `fft_last` sample, the bank becomes FREE and the read bank toggles.
  - If the other bank is already FULL, its first sample appears 2 cycles later; otherwise -> O_IDLE.
- Simultaneous events:
  - Fetch and drain proceed concurrently on different banks.
  - A bank freed in cycle t may start FILLING at t+1 at the earliest.
- Reset mid-operation:
  - The frame in flight is discarded; the upstream burst stops immediately.
  - The upstream module is also reset by the same `reset` signal.

Decomposition:
- Shared package holds:
  - bank-state encoding (FREE, FILLING, FULL, DRAINING);
  - fetch and output FSM state typedefs;
  - ADDR_W = $clog2(N);
  - a bitrev function parameterised on ADDR_W.
- One sub-module: fft_pingpong_ram, a simple dual-port RAM of 2*N words, Q_DATA+1 bits wide. Bank-select bit is the address MSB; one write port; one registered read port.

Test Plan:
- Single frame, N=8, ramp inputs 0..7, `fft_ready`=1 -> outputs 0,4,2,6,1,5,3,7 on consecutive cycles; `fft_last` only with 7; `fft_im`=0 throughout.
- Three `paquet_ready` pulses 4 cycles apart, `fft_ready`=1 -> three N-cycle `valid_fft` bursts separated by at least 1 idle cycle; 3 frames out in order; `overflow`=0.
- `fft_ready` toggled 1,0,0,1 repeatedly -> `fft_re` stable while stalled; no sample dropped or duplicated; N accepted samples per frame.
- `fft_ready`=0 for a long stretch with 5 `paquet_ready` pulses -> `valid_fft` stops after both banks are FULL; pending count reaches 3; the 5th pulse sets `overflow`=1, which stays high.
- `valid_in` injected with no fetch active -> sample ignored; `overflow`=1.
- Reset asserted mid-burst (sample 3 of 8) -> `valid_fft`, `fft_valid` and `overflow` go 0 immediately; the next `paquet_ready` fills bank 0 from address 0.
